// File: rtl/lfsr_share_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_share_ctrl
//   Shares one Galois LFSR (right-shift form) among NREQ requesters.
//   A round-robin arbiter grants at most one requester per cycle. Each grant
//   consumes exactly one LFSR step, so every grantee gets a distinct value.
//   Seeding forces a zero seed to 1. Every seed load, including reset, is
//   followed by WARMUP free-running steps before the first grant.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   i_seed_load  load i_seed this cycle (highest priority, any state)
//   i_seed       seed value, sampled when i_seed_load=1
//   i_req        request vector; req[i] is held until gnt[i] is seen
//   o_gnt        registered one-hot grant, one-cycle pulse
//   o_rand_out   LFSR value handed to the grantee; valid while o_gnt != 0
//   o_busy       high while the warm-up run is in progress
//   o_wrap       pulse: the last step returned the LFSR to the loaded seed
// ---------------------------------------------------------------------------
module lfsr_share_ctrl #(
  parameter int               WIDTH     = 8,
  parameter int               NREQ      = 4,
  parameter logic [WIDTH-1:0] TAPS      = 'hB8,
  parameter logic [WIDTH-1:0] SEED_INIT = 'h01,
  parameter int               WARMUP    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [NREQ-1:0]  i_req,
  output logic [NREQ-1:0]  o_gnt,
  output logic [WIDTH-1:0] o_rand_out,
  output logic             o_busy,
  output logic             o_wrap
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WARMUP);

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_SERVE  = 1'b1
  } state_t;

  // With no warm-up configured, a seed load goes straight to serving.
  localparam state_t ST_AFTER_LOAD = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_lfsr, w_lfsr_nxt;
  logic [WIDTH-1:0] r_seed, w_seed_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [WIDTH-1:0] r_rand, w_rand_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic             r_wrap, w_wrap_nxt;

  logic [WIDTH-1:0] w_lfsr_step;
  logic [WIDTH-1:0] w_seed_fix;
  logic [NREQ-1:0]  w_req_hi;
  logic [PW-1:0]    w_pick;
  logic             w_any;
  logic             w_step;

  // One Galois step in right-shift form.
  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  assign w_seed_fix = (i_seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : i_seed;

  assign w_any = |i_req;

  // Requests at or above the round-robin pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign w_req_hi[gi] = i_req[gi] & (PW'(gi) >= r_ptr);
  end

  // Round-robin pick. The lowest set bit at or above the pointer wins.
  // If no such bit is set, the search wraps to the lowest set bit overall.
  // Both loops run from the top down, so the lowest set index is assigned last.
  always_comb begin
    w_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) w_pick = PW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_req_hi[i]) w_pick = PW'(i);
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    w_seed_nxt  = r_seed;
    w_gnt_nxt   = '0;
    w_rand_nxt  = r_rand;
    w_ptr_nxt   = r_ptr;
    w_wrap_nxt  = 1'b0;
    w_step      = 1'b0;

    if (i_seed_load) begin
      // A load never steps and never grants. Pending requests simply wait.
      w_seed_nxt  = w_seed_fix;
      w_lfsr_nxt  = w_seed_fix;
      w_cnt_nxt   = CNT_INIT;
      w_state_nxt = ST_AFTER_LOAD;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_SERVE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
            w_step    = 1'b1;
          end
        end
        ST_SERVE: begin
          if (w_any) begin
            w_gnt_nxt  = NREQ'(1) << w_pick;
            w_rand_nxt = r_lfsr;
            w_ptr_nxt  = (w_pick == PW'(NREQ - 1)) ? '0 : (w_pick + 1'b1);
            w_step     = 1'b1;
          end
        end
        default: w_state_nxt = ST_WARMUP;
      endcase
    end

    if (w_step) begin
      w_lfsr_nxt = w_lfsr_step;
      w_wrap_nxt = (w_lfsr_step == r_seed);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WARMUP;
      r_cnt   <= CNT_INIT;
      r_lfsr  <= SEED_INIT;
      r_seed  <= SEED_INIT;
      r_gnt   <= '0;
      r_rand  <= '0;
      r_ptr   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_seed  <= w_seed_nxt;
      r_gnt   <= w_gnt_nxt;
      r_rand  <= w_rand_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_rand_out = r_rand;
  assign o_busy     = (r_state == ST_WARMUP);
  assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_share_ctrl
//   dut_a (WARMUP=4) is driven from a table of hand-computed vectors.
//   dut_b (WARMUP=0) runs a long continuous-request sequence that covers the
//   LFSR period, the wrap pulse and a reset applied mid-run.
// ---------------------------------------------------------------------------
module tb_lfsr_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic       a_rst, a_ld;
  logic [7:0] a_seed;
  logic [3:0] a_req;
  logic [3:0] a_gnt;
  logic [7:0] a_rand;
  logic       a_busy, a_wrap;

  // dut_b signals
  logic       b_rst, b_ld;
  logic [7:0] b_seed;
  logic [3:0] b_req;
  logic [3:0] b_gnt;
  logic [7:0] b_rand;
  logic       b_busy, b_wrap;

  lfsr_share_ctrl #(.WIDTH(8), .NREQ(4), .TAPS(8'hB8), .SEED_INIT(8'h01), .WARMUP(4)) dut_a (
    .clk(clk), .rst(a_rst), .i_seed_load(a_ld), .i_seed(a_seed), .i_req(a_req),
    .o_gnt(a_gnt), .o_rand_out(a_rand), .o_busy(a_busy), .o_wrap(a_wrap)
  );

  lfsr_share_ctrl #(.WIDTH(8), .NREQ(4), .TAPS(8'hB8), .SEED_INIT(8'h01), .WARMUP(0)) dut_b (
    .clk(clk), .rst(b_rst), .i_seed_load(b_ld), .i_seed(b_seed), .i_req(b_req),
    .o_gnt(b_gnt), .o_rand_out(b_rand), .o_busy(b_busy), .o_wrap(b_wrap)
  );

  typedef struct {
    logic       ld;
    logic [7:0] seed;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] rnd;
    logic       busy;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic add(input logic ld, input logic [7:0] seed, input logic [3:0] req,
                     input logic [3:0] gnt, input logic [7:0] rnd, input logic busy);
    vec_t v;
    v.ld = ld; v.seed = seed; v.req = req; v.gnt = gnt; v.rnd = rnd; v.busy = busy; v.wrap = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int wraps;
  int bad_gnt;

  initial begin
    a_rst = 1'b1; a_ld = 1'b0; a_seed = 8'h00; a_req = 4'b0000;
    b_rst = 1'b1; b_ld = 1'b0; b_seed = 8'h00; b_req = 4'b0000;

    // Warm-up from SEED_INIT 0x01: B8, 5C, 2E, 17, then one idle transition cycle.
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h00, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h00, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h00, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h00, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h00, 0);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h00, 0);
    // Single requester: 0x17, then 0xB3.
    add(0, 8'h00, 4'b0001, 4'b0001, 8'h17, 0);
    add(0, 8'h00, 4'b0001, 4'b0001, 8'hB3, 0);
    // All requesting, pointer at 1: rotation with consecutive LFSR values.
    add(0, 8'h00, 4'b1111, 4'b0010, 8'hE1, 0);
    add(0, 8'h00, 4'b1111, 4'b0100, 8'hC8, 0);
    add(0, 8'h00, 4'b1111, 4'b1000, 8'h64, 0);
    add(0, 8'h00, 4'b1111, 4'b0001, 8'h32, 0);
    add(0, 8'h00, 4'b1111, 4'b0010, 8'h19, 0);
    add(0, 8'h00, 4'b1111, 4'b0100, 8'hB4, 0);
    add(0, 8'h00, 4'b1111, 4'b1000, 8'h5A, 0);
    add(0, 8'h00, 4'b1111, 4'b0001, 8'h2D, 0);
    // Pointer to 2, then wrap-around pick of requester 0.
    add(0, 8'h00, 4'b0010, 4'b0010, 8'hAE, 0);
    add(0, 8'h00, 4'b0011, 4'b0001, 8'h57, 0);
    // Pointer to 2 again, then 1011 picks requester 3.
    add(0, 8'h00, 4'b0010, 4'b0010, 8'h93, 0);
    add(0, 8'h00, 4'b1011, 4'b1000, 8'hF1, 0);
    // No request: rand_out holds.
    add(0, 8'h00, 4'b0000, 4'b0000, 8'hF1, 0);
    // Zero seed load with a request pending: no grant, warm-up from 0x01.
    add(1, 8'h00, 4'b0010, 4'b0000, 8'hF1, 1);
    add(0, 8'h00, 4'b0010, 4'b0000, 8'hF1, 1);
    add(0, 8'h00, 4'b0010, 4'b0000, 8'hF1, 1);
    add(0, 8'h00, 4'b0010, 4'b0000, 8'hF1, 1);
    add(0, 8'h00, 4'b0010, 4'b0000, 8'hF1, 1);
    add(0, 8'h00, 4'b0010, 4'b0000, 8'hF1, 0);
    add(0, 8'h00, 4'b0010, 4'b0010, 8'h17, 0);
    // Seed 0x17, then reload 0x01 mid warm-up: the warm-up restarts from 0x01.
    add(1, 8'h17, 4'b0000, 4'b0000, 8'h17, 1);
    add(1, 8'h01, 4'b0000, 4'b0000, 8'h17, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h17, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h17, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h17, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h17, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 8'h17, 0);
    add(0, 8'h00, 4'b0001, 4'b0001, 8'h17, 0);
    add(0, 8'h00, 4'b0001, 4'b0001, 8'hB3, 0);

    step();
    step();
    chk("a_reset_gnt",  a_gnt,  4'b0000);
    chk("a_reset_rand", a_rand, 8'h00);
    chk("a_reset_busy", a_busy, 1'b1);
    chk("a_reset_wrap", a_wrap, 1'b0);
    a_rst = 1'b0;

    foreach (vecs[i]) begin
      a_ld = vecs[i].ld; a_seed = vecs[i].seed; a_req = vecs[i].req;
      step();
      $display("vec %0d ld=%b seed=%h req=%b -> gnt=%b rand=%h busy=%b wrap=%b",
               i, a_ld, a_seed, a_req, a_gnt, a_rand, a_busy, a_wrap);
      chk($sformatf("v%0d_gnt", i),  a_gnt,  vecs[i].gnt);
      chk($sformatf("v%0d_rand", i), a_rand, vecs[i].rnd);
      chk($sformatf("v%0d_busy", i), a_busy, vecs[i].busy);
      chk($sformatf("v%0d_wrap", i), a_wrap, vecs[i].wrap);
    end
    a_ld = 1'b0; a_req = 4'b0000;

    // dut_b, WARMUP=0: serves from the first edge after reset.
    chk("b_reset_busy", b_busy, 1'b1);
    b_rst = 1'b0;
    step();
    $display("b release: gnt=%b busy=%b", b_gnt, b_busy);
    chk("b_serve_busy", b_busy, 1'b0);
    chk("b_serve_gnt",  b_gnt,  4'b0000);

    // Continuous requests over two LFSR periods. Grant 255 returns to 0x01.
    b_req = 4'b0001;
    wraps = 0;
    bad_gnt = 0;
    for (int n = 1; n <= 520; n++) begin
      step();
      if (b_gnt !== 4'b0001) bad_gnt++;
      if (n == 1) chk("b_grant1_rand", b_rand, 8'h01);
      if (n == 2) chk("b_grant2_rand", b_rand, 8'hB8);
      if (b_wrap) begin
        wraps++;
        $display("b wrap at grant %0d rand=%h", n, b_rand);
        chk("b_wrap_at", n, (wraps == 1) ? 255 : 510);
        chk("b_wrap_rand", b_rand, 8'h02);
      end
    end
    chk("b_wrap_count", wraps, 2);
    chk("b_gnt_steady", bad_gnt, 0);

    // Asynchronous reset mid-run while a grant pulse is visible.
    chk("b_pre_rst_gnt", b_gnt, 4'b0001);
    b_rst = 1'b1;
    #1;
    $display("b mid-run reset: gnt=%b rand=%h busy=%b", b_gnt, b_rand, b_busy);
    chk("b_rst_gnt",  b_gnt,  4'b0000);
    chk("b_rst_rand", b_rand, 8'h00);
    chk("b_rst_busy", b_busy, 1'b1);
    chk("b_rst_wrap", b_wrap, 1'b0);
    step();
    b_rst = 1'b0;
    step();
    chk("b_rerun_gnt0", b_gnt, 4'b0000);
    step();
    $display("b after reset: gnt=%b rand=%h", b_gnt, b_rand);
    chk("b_rerun_gnt",  b_gnt,  4'b0001);
    chk("b_rerun_rand", b_rand, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_share_ctrl.md
Name: lfsr_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one Galois LFSR random source among NREQ requesters.
- Handles seeding, zero-seed lockup avoidance and a post-seed warm-up run.
- Grants at most one requester per cycle; each grant consumes exactly one LFSR step, so every grantee receives a distinct value.
- Sits between the pseudo-random datapath and its consumers (test-pattern generators, random-delay units).

Parameters:
- WIDTH, 8, LFSR state width in bits.
- NREQ, 4, number of requesters.
- TAPS, 8'hB8, Galois feedback mask, right-shift form; the default is maximal-length for WIDTH=8.
- SEED_INIT, 8'h01, state loaded on reset; must be nonzero.
- WARMUP, 4, LFSR steps run after every seed load before any grant is issued; 0 is legal.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- seed_load  in  1  load seed this cycle.
- seed  in  WIDTH  seed value, sampled when seed_load=1.
- req  in  NREQ  request vector; requester i holds req[i] high until it sees gnt[i].
- gnt  out  NREQ  registered one-hot grant, one-cycle pulse.
- rand_out  out  WIDTH  registered random value, valid only in the cycle gnt is nonzero.
- busy  out  1  high while in WARMUP.
- wrap  out  1  one-cycle pulse: the LFSR step just taken returned the state to the last loaded seed.

Behaviour:
- LFSR step:
  - if lfsr[0]=1: lfsr <= (lfsr>>1) ^ TAPS
  - else: lfsr <= lfsr>>1
- The state never steps except as listed below.
- Reset (async):
  - lfsr=SEED_INIT, seed_reg=SEED_INIT, gnt=0, rand_out=0, wrap=0, busy=1.
  - FSM=WARMUP, cnt=WARMUP, rr_ptr=0 (requester 0 highest priority).
  - If WARMUP=0, the FSM enters SERVE on the first edge after reset and busy=0.
- FSM states: WARMUP, SERVE.
- WARMUP:
  - LFSR steps every cycle; cnt decrements.
  - When cnt reaches 0 (no step that cycle), go to SERVE.
  - gnt=0 throughout; busy=1.
  - Exactly WARMUP steps are taken.
- SERVE:
  - At edge t, if any req bit is high, pick the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - For the pick k, at t+1: gnt=onehot(k), rand_out = lfsr value before edge t.
  - At edge t the LFSR steps once and rr_ptr <= (k+1) mod NREQ.
  - With no requests: no step, gnt=0, rand_out holds its last value.
- Requester protocol:
  - req[i] is sampled every cycle, so requester i deasserts req[i] in the cycle gnt[i] is seen.
  - A req[i] still high in that cycle counts as a new request, and rr_ptr has moved past i.
- Throughput: one grant per cycle under continuous requests. Latency from req sample to gnt is one cycle.
- Fairness: with all requesters permanently active, grants rotate 0,1,…,NREQ-1,0,… and no requester waits more than NREQ-1 grants.
- seed_load (any state, highest priority):
  - seed_reg and lfsr <= (seed==0 ? 1 : seed).
  - cnt <= WARMUP; FSM <= WARMUP (SERVE if WARMUP=0).
  - No grant is issued for that edge; any pending requests stay pending.
  - rr_ptr is not changed.
  - seed_load during WARMUP restarts the warm-up from the new seed.
- wrap:
  - Asserted the cycle after any step whose next state equals seed_reg, in either WARMUP or SERVE.
  - Never asserted on the load itself.
- Reset mid-operation: immediate return to reset values; an in-flight gnt pulse is dropped.
- Width rules: rand_out is the full WIDTH state. The state is never 0 given a nonzero SEED_INIT.

Test Plan:
1. Reset, WARMUP=4, no requests -> busy high 4 cycles, then low. lfsr passes 0xB8, 0x5C, 0x2E, 0x17 and holds at 0x17 with no req.
2. After test 1, req=4'b0001 for one cycle -> next cycle gnt=0001, rand_out=0x17. Next req=0001 -> rand_out=0xB3.
3. req=4'b1111 held 8 cycles after warm-up -> gnt sequence 0001, 0010, 0100, 1000, 0001, … Eight distinct consecutive LFSR values with no gaps.
4. rr_ptr=2 (last grant to 1), req=4'b0011 -> gnt=0001 (wrap-around). With req=4'b1011 instead -> gnt=1000.
5. seed_load=1 with seed=0x00 while req=4'b0010 pending -> no gnt that cycle, lfsr=0x01, busy for 4 cycles. Then gnt=0010, rand_out=0x17.
6. Seed 0x01, WARMUP=0, req=4'b0001 continuously -> wrap pulses exactly once per 255 grants, the cycle after the 255th step. Assert rst mid-run -> gnt=0, lfsr=0x01 immediately.
